// File: rtl/memory_map_pkg.sv
// Address map shared by the data bus responder and its timer.
package memory_map;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h8000_0000;

  localparam logic [4:0] GPIO_OUT_OFFSET      = 5'h00;
  localparam logic [4:0] GPIO_IN_OFFSET       = 5'h04;
  localparam logic [4:0] TIMER_COUNT_OFFSET   = 5'h08;
  localparam logic [4:0] TIMER_COMPARE_OFFSET = 5'h0C;
  localparam logic [4:0] TIMER_STATUS_OFFSET  = 5'h10;

  localparam int unsigned TIMER_PENDING_BIT = 0;
  localparam int unsigned TIMER_ENABLE_BIT  = 1;

  typedef enum logic [1:0] {
    RAM_REGION,
    MMIO_REGION,
    UNMAPPED
  } region_t;

endpackage

// File: rtl/machine_timer.sv
// Free-running 32-bit timer with compare-match pending flag.
module machine_timer
  import memory_map::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        count_we,
  input  logic [31:0] count_wdata,
  input  logic        compare_we,
  input  logic [31:0] compare_wdata,
  input  logic        status_we,
  input  logic [1:0]  status_wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        enable,
  output logic        pending
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        enable_q, enable_d;
  logic        pending_q, pending_d;
  logic [31:0] count_inc;
  logic        match;

  assign count_inc = count_q + 32'd1;

  // A software count write suppresses both the increment and the match test.
  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    enable_d  = enable_q;
    pending_d = pending_q;
    match     = 1'b0;

    if (count_we) begin
      count_d = count_wdata;
    end else if (enable_q) begin
      count_d = count_inc;
      match   = (count_inc == compare_q);
    end

    if (compare_we) compare_d = compare_wdata;
    if (status_we) begin
      enable_d = status_wdata[TIMER_ENABLE_BIT];
      if (status_wdata[TIMER_PENDING_BIT]) pending_d = 1'b0;
    end
    // Set wins over a same-cycle clear.
    if (match) pending_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q   <= 32'd0;
      compare_q <= 32'hFFFF_FFFF;
      enable_q  <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      enable_q  <= enable_d;
      pending_q <= pending_d;
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign enable  = enable_q;
  assign pending = pending_q;

endmodule

// File: rtl/data_bus_responder.sv
// CPU data bus responder: word RAM plus GPIO/timer MMIO window,
// zero-latency reads and next-edge writes.
module data_bus_responder
  import memory_map::*;
#(
  parameter int unsigned RAM_WORDS  = 256,
  parameter int unsigned GPIO_WIDTH = 8,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           address,
  input  logic                  write_enable,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic                  timer_interrupt
);

  localparam int unsigned AW        = $clog2(RAM_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

  region_t         region_c;
  logic [4:0]      mmio_off;
  logic [AW-1:0]   ram_idx;
  logic            ram_we, mmio_we;
  logic            gpio_we, count_we, compare_we, status_we;

  logic [31:0]           ram_q [RAM_WORDS];
  logic [GPIO_WIDTH-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_WIDTH-1:0] sync1_q, sync1_d;
  logic [GPIO_WIDTH-1:0] sync2_q, sync2_d;

  logic [31:0] tmr_count, tmr_compare;
  logic        tmr_enable, tmr_pending;

  // Address decode; RAM takes priority should the windows ever overlap.
  always_comb begin
    region_c = UNMAPPED;
    if ({1'b0, address} < RAM_BYTES) begin
      region_c = RAM_REGION;
    end else if (address[31:5] == MMIO_BASE[31:5]) begin
      region_c = MMIO_REGION;
    end
  end

  assign mmio_off   = {address[4:2], 2'b00};
  assign ram_idx    = address[AW+1:2];
  assign ram_we     = write_enable && (region_c == RAM_REGION);
  assign mmio_we    = write_enable && (region_c == MMIO_REGION);
  assign gpio_we    = mmio_we && (mmio_off == GPIO_OUT_OFFSET);
  assign count_we   = mmio_we && (mmio_off == TIMER_COUNT_OFFSET);
  assign compare_we = mmio_we && (mmio_off == TIMER_COMPARE_OFFSET);
  assign status_we  = mmio_we && (mmio_off == TIMER_STATUS_OFFSET);

  // Data RAM is not reset; a store sampled while reset is low is dropped.
  always_ff @(posedge clock) begin
    if (ram_we && reset) ram_q[ram_idx] <= write_data;
  end

  always_comb begin
    gpio_out_d = gpio_out_q;
    if (gpio_we) gpio_out_d = write_data[GPIO_WIDTH-1:0];
    sync1_d = gpio_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
    end else begin
      gpio_out_q <= gpio_out_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
    end
  end

  machine_timer u_timer (
    .clock         (clock),
    .reset         (reset),
    .count_we      (count_we),
    .count_wdata   (write_data),
    .compare_we    (compare_we),
    .compare_wdata (write_data),
    .status_we     (status_we),
    .status_wdata  (write_data[1:0]),
    .count         (tmr_count),
    .compare       (tmr_compare),
    .enable        (tmr_enable),
    .pending       (tmr_pending)
  );

  // Read mux: pure function of address and current state.
  always_comb begin
    read_data = 32'd0;
    case (region_c)
      RAM_REGION: read_data = ram_q[ram_idx];
      MMIO_REGION: begin
        case (mmio_off)
          GPIO_OUT_OFFSET:      read_data = 32'(gpio_out_q);
          GPIO_IN_OFFSET:       read_data = 32'(sync2_q);
          TIMER_COUNT_OFFSET:   read_data = tmr_count;
          TIMER_COMPARE_OFFSET: read_data = tmr_compare;
          TIMER_STATUS_OFFSET: begin
            read_data[TIMER_PENDING_BIT] = tmr_pending;
            read_data[TIMER_ENABLE_BIT]  = tmr_enable;
          end
          default: read_data = 32'd0;
        endcase
      end
      default: read_data = 32'd0;
    endcase
  end

  assign gpio_out        = gpio_out_q;
  assign timer_interrupt = tmr_pending;

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder with a behavioural memory-map model.
module tb_data_bus_responder;

  localparam int unsigned RAM_WORDS = 256;
  localparam logic [31:0] MBASE     = 32'h8000_0000;
  localparam logic [31:0] A_GOUT    = 32'h8000_0000;
  localparam logic [31:0] A_GIN     = 32'h8000_0004;
  localparam logic [31:0] A_CNT     = 32'h8000_0008;
  localparam logic [31:0] A_CMP     = 32'h8000_000C;
  localparam logic [31:0] A_STAT    = 32'h8000_0010;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = 32'd0;
  logic        write_enable = 1'b0;
  logic [31:0] write_data = 32'd0;
  logic [31:0] read_data;
  logic [7:0]  gpio_in = 8'd0;
  logic [7:0]  gpio_out;
  logic        timer_interrupt;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  data_bus_responder #(.RAM_WORDS(RAM_WORDS), .GPIO_WIDTH(8), .MMIO_BASE(MBASE)) dut (
    .clock           (clock),
    .reset           (reset),
    .address         (address),
    .write_enable    (write_enable),
    .write_data      (write_data),
    .read_data       (read_data),
    .gpio_in         (gpio_in),
    .gpio_out        (gpio_out),
    .timer_interrupt (timer_interrupt)
  );

  always #5 clock = ~clock;

  // Behavioural model of the memory map
  logic [31:0] m_ram [RAM_WORDS];
  bit          m_ok  [RAM_WORDS];
  logic [7:0]  m_gpo = 8'd0;
  logic [7:0]  m_hist [2] = '{8'd0, 8'd0};
  logic [31:0] m_cnt = 32'd0;
  logic [31:0] m_cmp = 32'hFFFF_FFFF;
  bit          m_en = 1'b0;
  bit          m_pend = 1'b0;

  function automatic bit in_ram(input logic [31:0] a);
    return a < RAM_WORDS * 4;
  endfunction

  function automatic bit in_mmio(input logic [31:0] a);
    return (a >= MBASE) && ((a - MBASE) < 32);
  endfunction

  function automatic bit m_read(input logic [31:0] a, output logic [31:0] v);
    int w;
    v = 32'd0;
    if (in_ram(a)) begin
      w = int'(a / 4);
      v = m_ram[w];
      return m_ok[w];
    end
    if (in_mmio(a)) begin
      case ((a - MBASE) / 4)
        0: v = {24'd0, m_gpo};
        1: v = {24'd0, m_hist[1]};
        2: v = m_cnt;
        3: v = m_cmp;
        4: v = {30'd0, m_en, m_pend};
        default: v = 32'd0;
      endcase
    end
    return 1'b1;
  endfunction

  task automatic model_edge();
    logic [31:0] next_cnt;
    bit next_pend;
    int reg_no;
    reg_no = in_mmio(address) ? int'((address - MBASE) / 4) : -1;
    next_cnt  = m_cnt;
    next_pend = m_pend;
    if (write_enable && reg_no == 4 && write_data[0]) next_pend = 1'b0;
    if (write_enable && reg_no == 2) begin
      next_cnt = write_data;
    end else if (m_en) begin
      next_cnt = m_cnt + 1;
      if (next_cnt == m_cmp) next_pend = 1'b1;
    end
    if (write_enable && in_ram(address)) begin
      m_ram[int'(address / 4)] = write_data;
      m_ok[int'(address / 4)]  = 1'b1;
    end
    if (write_enable && reg_no == 0) m_gpo = write_data[7:0];
    if (write_enable && reg_no == 3) m_cmp = write_data;
    if (write_enable && reg_no == 4) m_en = write_data[1];
    m_cnt  = next_cnt;
    m_pend = next_pend;
    m_hist[1] = m_hist[0];
    m_hist[0] = gpio_in;
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_gpo = 8'd0; m_hist[0] = 8'd0; m_hist[1] = 8'd0;
      m_cnt = 32'd0; m_cmp = 32'hFFFF_FFFF; m_en = 1'b0; m_pend = 1'b0;
    end else begin
      model_edge();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clock) begin
    logic [31:0] ev;
    if (started) begin
      chk("cmp_gpio_out", {24'd0, gpio_out}, {24'd0, m_gpo});
      chk("cmp_timer_interrupt", {31'd0, timer_interrupt}, {31'd0, m_pend});
      if (m_read(address, ev)) chk("cmp_read_data", read_data, ev);
    end
  end

  task automatic access(input logic [31:0] a, input logic we, input logic [31:0] wd);
    @(posedge clock);
    #1;
    address = a; write_enable = we; write_data = wd;
    @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < RAM_WORDS; i++) m_ok[i] = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    started = 1'b1;

    access(A_GOUT, 0, 0); chk("rst_gpio_out_read", read_data, 32'h0);
    access(A_CMP, 0, 0);  chk("rst_compare_read", read_data, 32'hFFFF_FFFF);
    access(A_STAT, 0, 0); chk("rst_status_read", read_data, 32'h0);
    chk("rst_irq", {31'd0, timer_interrupt}, 32'd0);

    access(32'h10, 1, 32'h1111_1111);
    access(32'h10, 1, 32'hDEAD_BEEF); chk("ram_same_cycle_old", read_data, 32'h1111_1111);
    access(32'h10, 0, 0); chk("ram_next_cycle", read_data, 32'hDEAD_BEEF);
    access(32'h13, 0, 0); chk("ram_low_bits_ignored", read_data, 32'hDEAD_BEEF);
    access(RAM_WORDS * 4, 0, 0); chk("ram_end_unmapped", read_data, 32'h0);
    access(32'h4000_0000, 1, 32'h1234);
    access(32'h4000_0000, 0, 0); chk("unmapped_read", read_data, 32'h0);
    access(32'h8000_0014, 1, 32'hFFFF);
    access(32'h8000_0014, 0, 0); chk("reserved_read", read_data, 32'h0);

    access(A_GOUT, 1, 32'h1A5);
    access(A_GOUT, 0, 0); chk("gpio_out_read", read_data, 32'hA5);
    chk("gpio_out_pin", {24'd0, gpio_out}, 32'hA5);

    access(A_GIN, 0, 0); gpio_in = 8'h3C; chk("gpio_in_0_edges", read_data, 32'h0);
    access(A_GIN, 0, 0); chk("gpio_in_1_edge", read_data, 32'h0);
    access(A_GIN, 0, 0); chk("gpio_in_2_edges", read_data, 32'h3C);

    access(A_CMP, 1, 5);
    access(A_CNT, 1, 0);
    access(A_STAT, 1, 2);
    for (int k = 1; k <= 6; k++) begin
      access(A_CNT, 0, 0);
      if (k == 5) chk("irq_before_5th_inc", {31'd0, timer_interrupt}, 32'd0);
      if (k == 6) begin
        chk("irq_after_5th_inc", {31'd0, timer_interrupt}, 32'd1);
        chk("count_at_match", read_data, 32'd5);
      end
    end
    access(A_STAT, 1, 1); chk("irq_w1c_same_cycle", {31'd0, timer_interrupt}, 32'd1);
    access(A_STAT, 0, 0); chk("irq_cleared", {31'd0, timer_interrupt}, 32'd0);
    chk("status_cleared", read_data, 32'd0);

    access(A_CMP, 1, 12);
    access(A_STAT, 1, 2);
    access(A_CNT, 1, 9);
    access(A_CNT, 0, 0); chk("count_override", read_data, 32'd9);
    access(A_CNT, 0, 0);
    access(A_STAT, 1, 3); chk("irq_before_match", {31'd0, timer_interrupt}, 32'd0);
    access(A_STAT, 0, 0); chk("set_wins_over_w1c", read_data, 32'd3);

    access(A_STAT, 1, 3);
    access(A_CMP, 1, 0);
    access(A_CNT, 1, 32'hFFFF_FFFE);
    access(A_CNT, 0, 0); chk("wrap_c1", read_data, 32'hFFFF_FFFE);
    access(A_CNT, 0, 0); chk("wrap_c2", read_data, 32'hFFFF_FFFF);
    chk("wrap_irq_low", {31'd0, timer_interrupt}, 32'd0);
    access(A_CNT, 0, 0); chk("wrap_c3", read_data, 32'h0);
    chk("wrap_irq_high", {31'd0, timer_interrupt}, 32'd1);

    access(A_GOUT, 1, 32'hFF);
    access(32'h10, 1, 32'h55);
    chk("pre_reset_gpio", {24'd0, gpio_out}, 32'hFF);
    chk("pre_reset_irq", {31'd0, timer_interrupt}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_gpio", {24'd0, gpio_out}, 32'h0);
    chk("async_reset_irq", {31'd0, timer_interrupt}, 32'd0);
    access(32'h10, 0, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    access(32'h10, 0, 0); chk("store_lost_in_reset", read_data, 32'hDEAD_BEEF);
    access(A_CMP, 0, 0);  chk("compare_after_reset", read_data, 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
